sc_opsequencer: RTL and testbench

Multi-cycle command sequencer for the micro-datapath (general/fixed registers, BUSA/BUSB muxes, ALU, shift register). It accepts one register-transfer command at a time over a valid/ready handshake and drives the datapath control buses cycle by cycle: operand read and ALU evaluation, load into the shift register, N shift steps, and write-back to a general register. When the sequence finishes it reports completion and the captured ALU flags. It replaces the hard-coded state table as the datapath's control source.

---
 rtl/sc_opsequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sc_opsequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sc_opsequencer.sv
// sc_opsequencer: multi-cycle register-transfer command sequencer.
// Accepts one command at a time over a valid/ready handshake. It then steps
// through EXEC (operand read + ALU + shift-register load), SHIFT (count steps),
// WRITE (general-register load) or CLEAR, and DONE (one-cycle done pulse).
// Ports:
//   CLOCK_50 / RESET_InHigh     : clock, synchronous active-high reset
//   cmd*                        : command handshake and fields
//   overflow/carry/negative/zero: ALU flags (active low), captured in EXEC
//   decoder*/mux*/alu*/regSHIFTER*: datapath control word (Moore, registered)
//   done_OutHigh / flags_OutBUS : completion pulse and captured flags
module sc_opsequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_SHIFTCOUNT           = 3
) (
  input  logic                                      SC_OPSEQUENCER_CLOCK_50,
  input  logic                                      SC_OPSEQUENCER_RESET_InHigh,
  input  logic                                      SC_OPSEQUENCER_cmdvalid_InHigh,
  output logic                                      SC_OPSEQUENCER_cmdready_OutHigh,
  input  logic                                      SC_OPSEQUENCER_cmdclear_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_OPSEQUENCER_cmdalu_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_cmdsrcA_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_cmdsrcB_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_OPSEQUENCER_cmddest_InBUS,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_OPSEQUENCER_cmdshiftdir_InBUS,
  input  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_OPSEQUENCER_cmdshiftcount_InBUS,
  input  logic                                      SC_OPSEQUENCER_overflow_InLow,
  input  logic                                      SC_OPSEQUENCER_carry_InLow,
  input  logic                                      SC_OPSEQUENCER_negative_InLow,
  input  logic                                      SC_OPSEQUENCER_zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_OPSEQUENCER_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_OPSEQUENCER_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_OPSEQUENCER_aluselection_OutBUS,
  output logic                                      SC_OPSEQUENCER_regSHIFTERclear_OutLow,
  output logic                                      SC_OPSEQUENCER_regSHIFTERload_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_OPSEQUENCER_regSHIFTERshiftselection_OutLow,
  output logic                                      SC_OPSEQUENCER_done_OutHigh,
  output logic [3:0]                                SC_OPSEQUENCER_flags_OutBUS
);

  localparam int DW = DATAWIDTH_DECODER_SELECTION;
  localparam int MW = DATAWIDTH_MUX_SELECTION;
  localparam int AW = DATAWIDTH_ALU_SELECTION;
  localparam int SW = DATAWIDTH_REGSHIFTER_SELECTION;
  localparam int CW = DATAWIDTH_SHIFTCOUNT;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic          lat_clear;
  logic [AW-1:0] lat_alu;
  logic [MW-1:0] lat_srca, lat_srcb;
  logic [DW-1:0] lat_dest;
  logic [SW-1:0] lat_dir;
  logic [CW-1:0] lat_count;
  logic [CW-1:0] shift_cnt;

  logic          accept;
  logic          eff_clear;
  logic [AW-1:0] eff_alu;
  logic [MW-1:0] eff_srca, eff_srcb;
  logic [DW-1:0] eff_dest, dest_sel;
  logic [SW-1:0] eff_dir;
  logic [CW-1:0] eff_count;

  logic [DW-1:0] n_dclr, n_dld;
  logic [MW-1:0] n_mux_a, n_mux_b;
  logic [AW-1:0] n_alu;
  logic          n_shld, n_ready, n_done;
  logic [SW-1:0] n_shsel;

  assign accept = (state == IDLE) && SC_OPSEQUENCER_cmdvalid_InHigh;

  // Outputs are registered from the next state, so the word for the first
  // busy cycle must see the command fields on the handshake edge itself.
  always_comb begin
    if (state == IDLE) begin
      eff_clear = SC_OPSEQUENCER_cmdclear_InHigh;
      eff_alu   = SC_OPSEQUENCER_cmdalu_InBUS;
      eff_srca  = SC_OPSEQUENCER_cmdsrcA_InBUS;
      eff_srcb  = SC_OPSEQUENCER_cmdsrcB_InBUS;
      eff_dest  = SC_OPSEQUENCER_cmddest_InBUS;
      eff_dir   = SC_OPSEQUENCER_cmdshiftdir_InBUS;
      eff_count = SC_OPSEQUENCER_cmdshiftcount_InBUS;
    end else begin
      eff_clear = lat_clear;
      eff_alu   = lat_alu;
      eff_srca  = lat_srca;
      eff_srcb  = lat_srcb;
      eff_dest  = lat_dest;
      eff_dir   = lat_dir;
      eff_count = lat_count;
    end
    dest_sel = (eff_dest <= DW'(3)) ? eff_dest : '1;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? (eff_clear ? CLEAR : EXEC) : IDLE;
      EXEC:    state_nxt = ((lat_dir == SW'(1) || lat_dir == SW'(2)) && lat_count != '0)
                           ? SHIFT : WRITE;
      SHIFT:   state_nxt = (shift_cnt <= CW'(1)) ? WRITE : SHIFT;
      WRITE:   state_nxt = DONE;
      CLEAR:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    n_dclr  = '1;
    n_dld   = '1;
    n_mux_a = '1;
    n_mux_b = '1;
    n_alu   = '1;
    n_shld  = 1'b1;
    n_shsel = '1;
    n_ready = 1'b0;
    n_done  = 1'b0;
    case (state_nxt)
      IDLE:  n_ready = 1'b1;
      EXEC: begin
        n_mux_a = eff_srca;
        n_mux_b = eff_srcb;
        n_alu   = eff_alu;
        n_shld  = 1'b0;
      end
      SHIFT: n_shsel = eff_dir;
      WRITE: n_dld   = dest_sel;
      CLEAR: n_dclr  = dest_sel;
      DONE:  n_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge SC_OPSEQUENCER_CLOCK_50) begin
    if (SC_OPSEQUENCER_RESET_InHigh) begin
      state     <= IDLE;
      shift_cnt <= '0;
      lat_clear <= 1'b0;
      lat_alu   <= '1;
      lat_srca  <= '1;
      lat_srcb  <= '1;
      lat_dest  <= '1;
      lat_dir   <= '1;
      lat_count <= '0;
      SC_OPSEQUENCER_flags_OutBUS                    <= '1;
      SC_OPSEQUENCER_decoderclearselection_OutBUS    <= '1;
      SC_OPSEQUENCER_decoderloadselection_OutBUS     <= '1;
      SC_OPSEQUENCER_muxselectionBUSA_OutBUS         <= '1;
      SC_OPSEQUENCER_muxselectionBUSB_OutBUS         <= '1;
      SC_OPSEQUENCER_aluselection_OutBUS             <= '1;
      SC_OPSEQUENCER_regSHIFTERclear_OutLow          <= 1'b1;
      SC_OPSEQUENCER_regSHIFTERload_OutLow           <= 1'b1;
      SC_OPSEQUENCER_regSHIFTERshiftselection_OutLow <= '1;
      SC_OPSEQUENCER_cmdready_OutHigh                <= 1'b1;
      SC_OPSEQUENCER_done_OutHigh                    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_clear <= SC_OPSEQUENCER_cmdclear_InHigh;
        lat_alu   <= SC_OPSEQUENCER_cmdalu_InBUS;
        lat_srca  <= SC_OPSEQUENCER_cmdsrcA_InBUS;
        lat_srcb  <= SC_OPSEQUENCER_cmdsrcB_InBUS;
        lat_dest  <= SC_OPSEQUENCER_cmddest_InBUS;
        lat_dir   <= SC_OPSEQUENCER_cmdshiftdir_InBUS;
        lat_count <= SC_OPSEQUENCER_cmdshiftcount_InBUS;
      end
      if (state == EXEC) begin
        shift_cnt <= lat_count;
        SC_OPSEQUENCER_flags_OutBUS <= {SC_OPSEQUENCER_overflow_InLow, SC_OPSEQUENCER_carry_InLow,
                                        SC_OPSEQUENCER_negative_InLow, SC_OPSEQUENCER_zero_InLow};
      end else if (state == SHIFT) begin
        shift_cnt <= shift_cnt - CW'(1);
      end
      SC_OPSEQUENCER_decoderclearselection_OutBUS    <= n_dclr;
      SC_OPSEQUENCER_decoderloadselection_OutBUS     <= n_dld;
      SC_OPSEQUENCER_muxselectionBUSA_OutBUS         <= n_mux_a;
      SC_OPSEQUENCER_muxselectionBUSB_OutBUS         <= n_mux_b;
      SC_OPSEQUENCER_aluselection_OutBUS             <= n_alu;
      SC_OPSEQUENCER_regSHIFTERclear_OutLow          <= 1'b1;
      SC_OPSEQUENCER_regSHIFTERload_OutLow           <= n_shld;
      SC_OPSEQUENCER_regSHIFTERshiftselection_OutLow <= n_shsel;
      SC_OPSEQUENCER_cmdready_OutHigh                <= n_ready;
      SC_OPSEQUENCER_done_OutHigh                    <= n_done;
    end
  end

endmodule

// File: tb/tb_sc_opsequencer.sv
// Testbench for sc_opsequencer: directed scenarios followed by random
// commands, each checked cycle by cycle against a per-command schedule of
// expected control words built from the command's fields.
module tb_sc_opsequencer;

  logic       clk = 1'b0;
  logic       rst, valid, ready, cclr;
  logic [3:0] calu;
  logic [2:0] csa, csb, cdest, ccnt;
  logic [1:0] cdir;
  logic       ov, ca, ne, ze;
  logic [2:0] dclr, dld, ma, mb;
  logic [3:0] alu;
  logic       shclr, shld, done;
  logic [1:0] shsel;
  logic [3:0] flags;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [3:0]  mflags;

  localparam logic [19:0] IDLE_W = '1;

  always #5 clk = ~clk;

  sc_opsequencer #(
    .DATAWIDTH_DECODER_SELECTION(3),
    .DATAWIDTH_MUX_SELECTION(3),
    .DATAWIDTH_ALU_SELECTION(4),
    .DATAWIDTH_REGSHIFTER_SELECTION(2),
    .DATAWIDTH_SHIFTCOUNT(3)
  ) dut (
    .SC_OPSEQUENCER_CLOCK_50(clk),
    .SC_OPSEQUENCER_RESET_InHigh(rst),
    .SC_OPSEQUENCER_cmdvalid_InHigh(valid),
    .SC_OPSEQUENCER_cmdready_OutHigh(ready),
    .SC_OPSEQUENCER_cmdclear_InHigh(cclr),
    .SC_OPSEQUENCER_cmdalu_InBUS(calu),
    .SC_OPSEQUENCER_cmdsrcA_InBUS(csa),
    .SC_OPSEQUENCER_cmdsrcB_InBUS(csb),
    .SC_OPSEQUENCER_cmddest_InBUS(cdest),
    .SC_OPSEQUENCER_cmdshiftdir_InBUS(cdir),
    .SC_OPSEQUENCER_cmdshiftcount_InBUS(ccnt),
    .SC_OPSEQUENCER_overflow_InLow(ov),
    .SC_OPSEQUENCER_carry_InLow(ca),
    .SC_OPSEQUENCER_negative_InLow(ne),
    .SC_OPSEQUENCER_zero_InLow(ze),
    .SC_OPSEQUENCER_decoderclearselection_OutBUS(dclr),
    .SC_OPSEQUENCER_decoderloadselection_OutBUS(dld),
    .SC_OPSEQUENCER_muxselectionBUSA_OutBUS(ma),
    .SC_OPSEQUENCER_muxselectionBUSB_OutBUS(mb),
    .SC_OPSEQUENCER_aluselection_OutBUS(alu),
    .SC_OPSEQUENCER_regSHIFTERclear_OutLow(shclr),
    .SC_OPSEQUENCER_regSHIFTERload_OutLow(shld),
    .SC_OPSEQUENCER_regSHIFTERshiftselection_OutLow(shsel),
    .SC_OPSEQUENCER_done_OutHigh(done),
    .SC_OPSEQUENCER_flags_OutBUS(flags)
  );

  function automatic logic [19:0] word();
    return {dclr, dld, ma, mb, alu, shclr, shld, shsel};
  endfunction

  function automatic logic [19:0] mk(logic [2:0] c, logic [2:0] l, logic [2:0] a,
                                     logic [2:0] b, logic [3:0] op, logic sl, logic [1:0] sh);
    return {c, l, a, b, op, 1'b1, sl, sh};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    {cclr, calu, csa, csb, cdest, cdir, ccnt} = 19'($urandom);
    {ov, ca, ne, ze} = 4'($urandom);
  endtask

  // One full command: handshake, every busy cycle, then the idle cycle after.
  task automatic run_cmd(input logic clr, input logic [3:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] d, input logic [1:0] dir,
                         input logic [2:0] cnt, input logic [3:0] xflags, input bit hold);
    int nsh, last;
    logic [2:0]  dsel;
    logic [19:0] exp_w;
    nsh  = (!clr && (dir == 2'b01 || dir == 2'b10)) ? int'(cnt) : 0;
    last = clr ? 2 : nsh + 3;
    dsel = (d <= 3'd3) ? d : 3'b111;
    check("ready_idle", 32'(ready), 32'(1));
    valid = 1'b1;
    cclr = clr; calu = op; csa = a; csb = b; cdest = d; cdir = dir; ccnt = cnt;
    step();
    if (!hold) valid = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (clr)             exp_w = (c == 1) ? mk(dsel, 3'h7, 3'h7, 3'h7, 4'hF, 1'b1, 2'b11) : IDLE_W;
      else if (c == 1)     exp_w = mk(3'h7, 3'h7, a, b, op, 1'b0, 2'b11);
      else if (c <= nsh+1) exp_w = mk(3'h7, 3'h7, 3'h7, 3'h7, 4'hF, 1'b1, dir);
      else if (c == nsh+2) exp_w = mk(3'h7, dsel, 3'h7, 3'h7, 4'hF, 1'b1, 2'b11);
      else                 exp_w = IDLE_W;
      check("ctl_word", 32'(word()), 32'(exp_w));
      check("ready_busy", 32'(ready), 32'(0));
      check("done", 32'(done), 32'(c == last));
      check("flags", 32'(flags), 32'(mflags));
      scramble();
      if (c == 1 && !clr) {ov, ca, ne, ze} = xflags;
      step();
      if (c == 1 && !clr) mflags = xflags;
    end
    valid = 1'b0;
    check("ready_after", 32'(ready), 32'(1));
    check("done_after", 32'(done), 32'(0));
    check("ctl_after", 32'(word()), 32'(IDLE_W));
    check("flags_after", 32'(flags), 32'(mflags));
    step();
    check("no_reaccept", 32'(word()), 32'(IDLE_W));
    check("ready_hold", 32'(ready), 32'(1));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0;
    scramble();
    mflags = 4'hF;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_ctl", 32'(word()), 32'(IDLE_W));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_flags", 32'(flags), 32'(4'hF));

    // ADD, no shift
    run_cmd(1'b0, 4'b1000, 3'b100, 3'b101, 3'b010, 2'b00, 3'd0, 4'hF, 1'b0);
    // left shift by 3, then count 0 and dir 11
    run_cmd(1'b0, 4'b0011, 3'b001, 3'b010, 3'b001, 2'b01, 3'd3, 4'hF, 1'b0);
    run_cmd(1'b0, 4'b0011, 3'b001, 3'b010, 3'b001, 2'b01, 3'd0, 4'hF, 1'b0);
    run_cmd(1'b0, 4'b0011, 3'b001, 3'b010, 3'b001, 2'b11, 3'd5, 4'hF, 1'b0);
    // right shift by 7, no-write destination
    run_cmd(1'b0, 4'b0101, 3'b110, 3'b000, 3'b110, 2'b10, 3'd7, 4'hF, 1'b0);
    // flag capture, then clears leave flags alone
    run_cmd(1'b0, 4'b0001, 3'b000, 3'b001, 3'b000, 2'b00, 3'd0, 4'b1110, 1'b0);
    run_cmd(1'b1, 4'b0000, 3'b000, 3'b000, 3'b011, 2'b00, 3'd0, 4'hF, 1'b0);
    run_cmd(1'b1, 4'b0000, 3'b000, 3'b000, 3'b101, 2'b00, 3'd0, 4'hF, 1'b0);
    run_cmd(1'b0, 4'b0001, 3'b000, 3'b001, 3'b000, 2'b00, 3'd0, 4'hF, 1'b0);
    // valid held high for the whole command
    run_cmd(1'b0, 4'b0110, 3'b011, 3'b010, 3'b011, 2'b10, 3'd2, 4'b0101, 1'b1);

    // reset during the second SHIFT cycle of a count-5 command
    valid = 1'b1;
    cclr = 1'b0; calu = 4'b1000; csa = 3'd1; csb = 3'd2; cdest = 3'd1; cdir = 2'b01; ccnt = 3'd5;
    step();
    valid = 1'b0;
    step();
    check("mid_shift1", 32'(word()), 32'(mk(3'h7, 3'h7, 3'h7, 3'h7, 4'hF, 1'b1, 2'b01)));
    step();
    check("mid_shift2", 32'(word()), 32'(mk(3'h7, 3'h7, 3'h7, 3'h7, 4'hF, 1'b1, 2'b01)));
    rst = 1'b1;
    valid = 1'b1;
    step();
    valid = 1'b0;
    rst = 1'b0;
    mflags = 4'hF;
    check("mid_rst_ctl", 32'(word()), 32'(IDLE_W));
    check("mid_rst_ready", 32'(ready), 32'(1));
    check("mid_rst_flags", 32'(flags), 32'(4'hF));
    for (int i = 0; i < 8; i++) begin
      step();
      check("abandon_ctl", 32'(word()), 32'(IDLE_W));
      check("abandon_done", 32'(done), 32'(0));
    end
    run_cmd(1'b0, 4'b1000, 3'b100, 3'b101, 3'b010, 2'b01, 3'd1, 4'b0011, 1'b0);

    // random commands
    for (int n = 0; n < 40; n++) begin
      run_cmd(($urandom_range(0, 3) == 0), 4'($urandom), 3'($urandom), 3'($urandom),
              3'($urandom), 2'($urandom), 3'($urandom), 4'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
